// File: rtl/lfsr_lock_monitor_if.sv
// Status bus between the LFSR checker side and the lock monitor.
//   i_valid         : strobe qualifying i_lock (shared with generator/checker)
//   i_lock          : raw lock flag from the checker
//   i_clear         : synchronous clear of monitor state and statistics
//   o_lock_stable   : debounced lock indication
//   o_state         : monitor state (IDLE=0, ACQ=1, LOCKED=2)
//   o_time_to_lock  : valid cycles taken by the most recent acquisition
//   o_loss_count    : saturating count of LOCKED-to-ACQ transitions
//   o_unlocked_cycles : saturating count of valid cycles with i_lock=0
//   o_alarm         : acquisition exceeded the timeout
// master drives the inputs and observes the results; slave is the monitor.
interface lfsr_lock_monitor_if #(
  parameter int CNT_W  = 16,
  parameter int LOSS_W = 8
);
  logic              i_valid;
  logic              i_lock;
  logic              i_clear;
  logic              o_lock_stable;
  logic [1:0]        o_state;
  logic [CNT_W-1:0]  o_time_to_lock;
  logic [LOSS_W-1:0] o_loss_count;
  logic [CNT_W-1:0]  o_unlocked_cycles;
  logic              o_alarm;

  modport master (
    output i_valid, i_lock, i_clear,
    input  o_lock_stable, o_state, o_time_to_lock, o_loss_count,
           o_unlocked_cycles, o_alarm
  );

  modport slave (
    input  i_valid, i_lock, i_clear,
    output o_lock_stable, o_state, o_time_to_lock, o_loss_count,
           o_unlocked_cycles, o_alarm
  );
endinterface

// File: rtl/lfsr_lock_monitor.sv
// Lock supervisor for the LFSR generator/checker pair.
// Debounces the checker lock flag into a stable-lock state, measures
// time-to-lock, counts lock losses and unlocked valid cycles, and raises a
// sticky alarm when acquisition takes TIMEOUT valid cycles.
//   clk     : rising-edge clock
//   i_rst_n : synchronous active-low reset
//   bus     : lfsr_lock_monitor_if slave modport (strobe/lock/clear in,
//             state and statistics out)
module lfsr_lock_monitor #(
  parameter int CNT_W     = 16,
  parameter int LOSS_W    = 8,
  parameter int LOCK_HOLD = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               i_rst_n,
  lfsr_lock_monitor_if.slave bus
);

  localparam int HOLD_W = $clog2(LOCK_HOLD + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_C    = HOLD_W'(LOCK_HOLD);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LOSS_W-1:0] sat_inc_loss(input logic [LOSS_W-1:0] v);
    return (v == {LOSS_W{1'b1}}) ? v : v + LOSS_W'(1);
  endfunction

  logic [1:0]        state;
  logic [CNT_W-1:0]  ttl_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  time_to_lock;
  logic [LOSS_W-1:0] loss_count;
  logic [CNT_W-1:0]  unlocked_cycles;
  logic              alarm;

  logic [CNT_W-1:0]  ttl_base;
  logic [HOLD_W-1:0] hold_base;
  logic [CNT_W-1:0]  ttl_next;
  logic [HOLD_W-1:0] hold_next;
  logic              hold_hit;

  // Acquisition step. IDLE is evaluated as an ACQ cycle from zeroed counters.
  // hold_base never exceeds LOCK_HOLD-1, so hold_base+1 always fits HOLD_W.
  always_comb begin
    ttl_base  = (state == ST_IDLE) ? '0 : ttl_cnt;
    hold_base = (state == ST_IDLE) ? '0 : hold_cnt;
    ttl_next  = sat_inc_cnt(ttl_base);
    hold_next = bus.i_lock ? hold_base + HOLD_W'(1) : '0;
    hold_hit  = (hold_next == HOLD_C);
  end

  // Clear is indistinguishable from reset and overrides any valid cycle.
  always_ff @(posedge clk) begin
    if (!i_rst_n || bus.i_clear) begin
      state           <= ST_IDLE;
      ttl_cnt         <= '0;
      hold_cnt        <= '0;
      time_to_lock    <= '0;
      loss_count      <= '0;
      unlocked_cycles <= '0;
      alarm           <= 1'b0;
    end else if (bus.i_valid) begin
      if (!bus.i_lock)
        unlocked_cycles <= sat_inc_cnt(unlocked_cycles);

      case (state)
        ST_LOCKED: begin
          // Any bad valid cycle drops lock; that cycle counts as the first
          // cycle of the new acquisition.
          if (!bus.i_lock) begin
            state      <= ST_ACQ;
            loss_count <= sat_inc_loss(loss_count);
            ttl_cnt    <= CNT_W'(1);
            hold_cnt   <= '0;
          end
        end
        default: begin
          if (hold_hit) begin
            state        <= ST_LOCKED;
            time_to_lock <= ttl_next;
            alarm        <= 1'b0;
            ttl_cnt      <= '0;
            hold_cnt     <= '0;
          end else begin
            state    <= ST_ACQ;
            ttl_cnt  <= ttl_next;
            hold_cnt <= hold_next;
            if (ttl_next == TIMEOUT_C)
              alarm <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.o_state           = state;
  assign bus.o_lock_stable     = (state == ST_LOCKED);
  assign bus.o_time_to_lock    = time_to_lock;
  assign bus.o_loss_count      = loss_count;
  assign bus.o_unlocked_cycles = unlocked_cycles;
  assign bus.o_alarm           = alarm;

endmodule

// File: doc/lfsr_lock_monitor.md
# lfsr_lock_monitor

Downstream supervisor for the LFSR generator/checker pair. It consumes the checker's lock flag and the shared valid strobe, then qualifies lock into a debounced stable-lock indication. It also measures time-to-lock, counts lock losses and unlocked valid cycles, and raises a timeout alarm. Its outputs feed the status/register layer and board LEDs.

## Interface
Parameters:
- CNT_W, 16: width of time-to-lock and unlocked-cycle counters.
- LOSS_W, 8: width of lock-loss counter.
- LOCK_HOLD, 4: consecutive locked valid cycles required for stable lock. Legal range is 1 to TIMEOUT-1.
- TIMEOUT, 64: valid cycles in acquisition before the alarm asserts. Must be below 2^CNT_W.

Ports:
- clk, input, 1: system clock, rising edge.
- i_rst_n, input, 1: reset, synchronous, active-low.
- i_valid, input, 1: qualifies i_lock. The same strobe also drives the generator/checker.
- i_lock, input, 1: lock flag from the checker (o_lock).
- i_clear, input, 1: synchronous clear of state and all statistics.
- o_lock_stable, output, 1: high while state is LOCKED.
- o_state, output, 2: current state. IDLE=0, ACQ=1, LOCKED=2. Encoding 3 is never produced.
- o_time_to_lock, output, CNT_W: valid cycles taken by the most recent acquisition.
- o_loss_count, output, LOSS_W: LOCKED-to-ACQ transitions, saturating.
- o_unlocked_cycles, output, CNT_W: valid cycles with i_lock=0, saturating.
- o_alarm, output, 1: acquisition exceeded TIMEOUT.

## Operation
- Internal registers:
  - ttl_cnt, CNT_W bits, counts valid cycles in the current acquisition.
  - hold_cnt, holds enough bits to reach LOCK_HOLD.
- Priority order: i_rst_n=0, then i_clear=1, then normal operation.
- Clear behaves exactly like reset. Any i_valid in the same cycle is ignored.
- Cycles with i_valid=0 change nothing. hold_cnt is retained, so gaps do not break a lock run.
- Unlocked-cycle counting: any valid cycle with i_lock=0, in any state, increments o_unlocked_cycles, saturating at 2^CNT_W-1.
- IDLE: the first valid cycle is evaluated as an ACQ cycle starting from ttl_cnt=0 and hold_cnt=0.
- ACQ, evaluated once per valid cycle:
  - ttl_next = sat(ttl_cnt+1).
  - hold_next = i_lock ? hold_cnt+1 : 0.
  - If hold_next==LOCK_HOLD: go to LOCKED, set o_time_to_lock<=ttl_next, set o_alarm<=0, reset ttl_cnt and hold_cnt to 0.
  - Else: store both next values, and set o_alarm<=1 if ttl_next==TIMEOUT.
- Alarm is sticky until the next LOCKED entry, clear, or reset.
- LOCKED:
  - Valid with i_lock=1: no change.
  - Valid with i_lock=0: go to ACQ, o_loss_count saturating +1, ttl_cnt=1, hold_cnt=0.
  - A single bad valid cycle always drops stable lock. No tolerance window.
- o_time_to_lock holds its last value while in ACQ. It reads 0 until the first lock.
- Saturation: ttl_cnt stops at all-ones. The alarm has already fired at TIMEOUT, and lock can still be acquired after saturation.

## Timing
- All outputs are registered. Effects of a valid cycle at edge N are visible after edge N.
- Reset values:
  - o_state=IDLE, o_lock_stable=0, o_alarm=0.
  - All counters 0, including internal ttl_cnt and hold_cnt.
- Minimum stable-lock latency: LOCK_HOLD valid cycles after the first valid cycle with i_lock=1.
- o_lock_stable falls one cycle after the first valid cycle with i_lock=0.
- Loss count and unlocked count update on the same edge.
- o_alarm rises on the edge that registers the TIMEOUT-th acquisition valid cycle.
- Reset or clear mid-acquisition or while LOCKED: returns to IDLE next edge. No partial statistics survive.

## Test plan
- Lock after misses, defaults: reset, then continuous valid with lock=0 ×3 then lock=1 ×4. Expect LOCKED after the 7th valid, o_time_to_lock=7, o_unlocked_cycles=3, o_loss_count=0.
- Gaps: lock=1 with valid alternating 1/0 for 8 cycles. Expect LOCKED after the 4th valid (cycle 7), o_time_to_lock=4, state unchanged on valid=0 cycles.
- Loss and reacquire: from LOCKED, one valid cycle with lock=0 then lock=1 ×4. Expect ACQ one cycle after the bad valid, o_loss_count=1, then LOCKED with o_time_to_lock=5.
- Timeout: from reset, 64 valid cycles with lock=0. Expect o_alarm=1 after the 64th and not before. Then lock=1 ×4: expect LOCKED, o_alarm=0, o_time_to_lock=68.
- Saturation with CNT_W=4 and LOSS_W=2:
  - Use TIMEOUT=8; the default TIMEOUT=64 is illegal at CNT_W=4.
  - 20 valid cycles with lock=0: expect o_unlocked_cycles=15.
  - 5 lock/loss cycles: expect o_loss_count=3.
- Clear and reset mid-operation:
  - In LOCKED, assert i_clear together with valid and lock=0. Expect IDLE, all counters 0, o_loss_count not incremented.
  - Repeat with i_rst_n=0 during ACQ. Expect identical zeroed state.
